instr_loader: RTL

Boot-time program loader for the RV32I pipeline. It accepts a byte stream holding a header, instruction words and a checksum, and assembles little-endian 32-bit words. Each word is written into instruction memory through a request/grant write port. Until a verified image is resident, it holds the core in reset and keeps memory disabled; on success it releases both (drives `mem_en`).

---
 rtl/instr_loader_if.sv | 32 +++
 rtl/instr_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface instr_loader_if;
  logic        rx_valid_ip;
  logic [7:0]  rx_data_ip;
  logic        rx_ready_op;
  logic        wr_req_op;
  logic [31:0] wr_addr_op;
  logic [31:0] wr_data_op;
  logic        wr_gnt_ip;

  // Loader side.
  modport master (
    input  rx_valid_ip,
    input  rx_data_ip,
    output rx_ready_op,
    output wr_req_op,
    output wr_addr_op,
    output wr_data_op,
    input  wr_gnt_ip
  );

  // Stream source / memory side.
  modport slave (
    output rx_valid_ip,
    output rx_data_ip,
    input  rx_ready_op,
    input  wr_req_op,
    input  wr_addr_op,
    input  wr_data_op,
    output wr_gnt_ip
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: parses header / payload / checksum from a byte
// stream, writes little-endian words to instruction memory and releases the
// core only once the whole image has been verified.
module instr_loader #(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS  = 127
) (
  input  logic           clock,
  input  logic           reset,
  instr_loader_if.master bus,
  output logic           core_hold_op,
  output logic           mem_en_op,
  output logic           done_op,
  output logic           error_op,
  output logic [31:0]    words_loaded_op
);

  typedef enum logic [2:0] {StHdr, StData, StWrite, StCsum, StDone, StErr} state_e;

  state_e      state_q;
  logic [31:0] byte_idx_q;
  logic [31:0] n_q;
  logic [31:0] word_q;
  logic [31:0] words_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic [31:0] n_nxt;
  logic [31:0] word_nxt;

  assign accept   = bus.rx_valid_ip && bus.rx_ready_op;
  // Bytes arrive LSB first, so shifting in from the top leaves them in place.
  assign n_nxt    = {bus.rx_data_ip, n_q[31:8]};
  assign word_nxt = {bus.rx_data_ip, word_q[31:8]};

  // Sequencer: stream parsing, word assembly, write handshake and verdict.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StHdr;
      byte_idx_q <= 32'd0;
      n_q        <= 32'd0;
      word_q     <= 32'd0;
      words_q    <= 32'd0;
      csum_q     <= 8'd0;
    end else begin
      unique case (state_q)
        StHdr: begin
          if (accept) begin
            n_q <= n_nxt;
            if (byte_idx_q == 32'd3) begin
              byte_idx_q <= 32'd0;
              if (n_nxt > 32'(MAX_WORDS)) begin
                state_q <= StErr;
              end else if (n_nxt == 32'd0) begin
                state_q <= StCsum;
              end else begin
                state_q <= StData;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 32'd1;
            end
          end
        end
        StData: begin
          if (accept) begin
            word_q <= word_nxt;
            csum_q <= csum_q ^ bus.rx_data_ip;
            if (byte_idx_q == 32'd3) begin
              byte_idx_q <= 32'd0;
              state_q    <= StWrite;
            end else begin
              byte_idx_q <= byte_idx_q + 32'd1;
            end
          end
        end
        StWrite: begin
          if (bus.wr_gnt_ip) begin
            words_q <= words_q + 32'd1;
            if (words_q + 32'd1 == n_q) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
        end
        StCsum: begin
          if (accept) begin
            state_q <= (bus.rx_data_ip == csum_q) ? StDone : StErr;
          end
        end
        StDone, StErr: begin
        end
        default: state_q <= StErr;
      endcase
    end
  end

  // Outputs decoded from state; only rx_ready additionally sees reset.
  always_comb begin
    bus.rx_ready_op = reset && (state_q == StHdr || state_q == StData || state_q == StCsum);
    bus.wr_req_op   = (state_q == StWrite);
    bus.wr_addr_op  = 32'd0;
    bus.wr_data_op  = 32'd0;
    if (state_q == StWrite) begin
      bus.wr_addr_op = START_ADDR + {words_q[29:0], 2'b00};
      bus.wr_data_op = word_q;
    end
    done_op         = (state_q == StDone);
    error_op        = (state_q == StErr);
    mem_en_op       = (state_q == StDone);
    core_hold_op    = (state_q != StDone);
    words_loaded_op = words_q;
  end

endmodule
